// File: rtl/ds_temp_ctrl.sv
// DS18B20 acquisition sequencer: drives the byte-level 1-Wire interface through
// reset / Skip ROM / Convert T / wait / reset / Skip ROM / Read Scratchpad / 2 reads.
module ds_temp_ctrl #(
  parameter int unsigned CONV_CYC = 37500000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic [15:0] temp_raw,
  output logic        temp_vld,
  output logic        rst_en,
  output logic        wr_en,
  output logic [7:0]  wdata,
  output logic        rd_en,
  input  logic [7:0]  rdata,
  input  logic        rdata_vld,
  input  logic        rdy
);

  localparam logic [7:0]       CMD_SKIP = 8'hCC;
  localparam logic [7:0]       CMD_CONV = 8'h44;
  localparam logic [7:0]       CMD_RDSP = 8'hBE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYC - 1);
  localparam logic [1:0]       AGE_MIN  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST1,
    S_SKP1,
    S_CNV,
    S_WAIT,
    S_RST2,
    S_SKP2,
    S_RSP,
    S_RDL,
    S_RDH,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RST,
    OP_WR,
    OP_RD
  } op_t;

  state_t           state, state_nxt;
  logic             issued, issued_nxt;
  logic [1:0]       age, age_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       lsb, lsb_nxt;
  logic [7:0]       msb, msb_nxt;

  logic             busy_nxt;
  logic [15:0]      temp_raw_nxt;
  logic             temp_vld_nxt;
  logic             rst_en_nxt;
  logic             wr_en_nxt;
  logic [7:0]       wdata_nxt;
  logic             rd_en_nxt;

  op_t              op_kind;
  logic [7:0]       op_byte;
  state_t           op_next;
  logic             req_active;
  logic             can_issue;
  logic             op_done;

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      issued   <= 1'b0;
      age      <= '0;
      cnt      <= '0;
      lsb      <= '0;
      msb      <= '0;
      busy     <= 1'b0;
      temp_raw <= '0;
      temp_vld <= 1'b0;
      rst_en   <= 1'b0;
      wr_en    <= 1'b0;
      wdata    <= '0;
      rd_en    <= 1'b0;
    end else begin
      state    <= state_nxt;
      issued   <= issued_nxt;
      age      <= age_nxt;
      cnt      <= cnt_nxt;
      lsb      <= lsb_nxt;
      msb      <= msb_nxt;
      busy     <= busy_nxt;
      temp_raw <= temp_raw_nxt;
      temp_vld <= temp_vld_nxt;
      rst_en   <= rst_en_nxt;
      wr_en    <= wr_en_nxt;
      wdata    <= wdata_nxt;
      rd_en    <= rd_en_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    issued_nxt   = issued;
    age_nxt      = (issued && (age != AGE_MIN)) ? age + 2'd1 : age;
    cnt_nxt      = cnt;
    lsb_nxt      = lsb;
    msb_nxt      = msb;
    busy_nxt     = busy;
    temp_raw_nxt = temp_raw;
    temp_vld_nxt = 1'b0;
    rst_en_nxt   = 1'b0;
    wr_en_nxt    = 1'b0;
    wdata_nxt    = wdata;
    rd_en_nxt    = 1'b0;
    op_kind      = OP_NONE;
    op_byte      = 8'h00;
    op_next      = S_IDLE;

    req_active = rst_en | wr_en | rd_en;
    can_issue  = !issued && rdy && !req_active;

    case (state)
      S_IDLE: begin
        // busy is still high here only during the temp_vld cycle; start is dropped then
        if (busy) begin
          busy_nxt = 1'b0;
        end else if (start) begin
          busy_nxt   = 1'b1;
          issued_nxt = 1'b0;
          state_nxt  = S_RST1;
        end
      end
      S_RST1: begin op_kind = OP_RST; op_next = S_SKP1; end
      S_SKP1: begin op_kind = OP_WR;  op_byte = CMD_SKIP; op_next = S_CNV;  end
      S_CNV:  begin op_kind = OP_WR;  op_byte = CMD_CONV; op_next = S_WAIT; end
      S_WAIT: begin
        // Conversion dwell of exactly CONV_CYC cycles
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_RST2;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RST2: begin op_kind = OP_RST; op_next = S_SKP2; end
      S_SKP2: begin op_kind = OP_WR;  op_byte = CMD_SKIP; op_next = S_RSP; end
      S_RSP:  begin op_kind = OP_WR;  op_byte = CMD_RDSP; op_next = S_RDL; end
      S_RDL:  begin op_kind = OP_RD;  op_next = S_RDH;  end
      S_RDH:  begin op_kind = OP_RD;  op_next = S_DONE; end
      S_DONE: begin
        temp_raw_nxt = {msb, lsb};
        temp_vld_nxt = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Reads finish on returned data; resets/writes on rdy, ignoring the first
    // two cycles after the pulse while the interface is still picking it up
    if (op_kind == OP_RD) begin
      op_done = issued && rdata_vld;
    end else begin
      op_done = issued && rdy && (age == AGE_MIN);
    end

    // Shared issue/complete handling for all byte-op states
    if (op_kind != OP_NONE) begin
      if (can_issue) begin
        issued_nxt = 1'b1;
        age_nxt    = 2'd0;
        case (op_kind)
          OP_RST:  rst_en_nxt = 1'b1;
          OP_WR: begin
            wr_en_nxt = 1'b1;
            wdata_nxt = op_byte;
          end
          OP_RD:   rd_en_nxt = 1'b1;
          default: issued_nxt = 1'b0;
        endcase
      end else if (op_done) begin
        issued_nxt = 1'b0;
        state_nxt  = op_next;
        if (state == S_RDL) lsb_nxt = rdata;
        if (state == S_RDH) msb_nxt = rdata;
      end
    end
  end

endmodule

// File: tb/tb_ds_temp_ctrl.sv
// Self-checking bench for ds_temp_ctrl: two instances (CONV_CYC=100 and 1), each
// driven by a behavioural byte-interface model (20-cycle ops, queued read bytes).
module tb_ds_temp_ctrl;

  typedef struct {
    int         kind;   // 1 = rst_en, 2 = wr_en, 3 = rd_en
    logic [7:0] data;
    int         cyc;
  } tr_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_op_t;

  typedef struct {
    logic [7:0]  lsb;
    logic [7:0]  msb;
    logic [15:0] raw;
    int          inst;
    int          stall;
    bit          drop;
  } vec_t;

  localparam int OP_LAT = 23;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  start_v = '0;
  logic [1:0]  stall   = '0;
  logic [1:0]  busy_v, temp_vld_v, rst_en_v, wr_en_v, rd_en_v, rdy_v;
  logic [1:0]  rdata_vld_v;
  logic [15:0] temp_raw_v [2];
  logic [7:0]  wdata_v [2];
  logic [7:0]  rdata_v [2];
  logic [7:0]  rbytes [2][2];
  int          mcnt [2];
  logic        mread [2];
  int          ridx [2];
  int          conv_of [2];

  tr_t         tr0[$];
  tr_t         tr1[$];
  int          viol [2];
  logic [2:0]  prev_req [2];
  logic [2:0]  mr;
  tr_t         mrec;

  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  exp_op_t     eops [8];
  vec_t        vecs [5];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ds_temp_ctrl #(.CONV_CYC(100), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]),
    .temp_raw(temp_raw_v[0]), .temp_vld(temp_vld_v[0]), .rst_en(rst_en_v[0]),
    .wr_en(wr_en_v[0]), .wdata(wdata_v[0]), .rd_en(rd_en_v[0]),
    .rdata(rdata_v[0]), .rdata_vld(rdata_vld_v[0]), .rdy(rdy_v[0])
  );

  ds_temp_ctrl #(.CONV_CYC(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]),
    .temp_raw(temp_raw_v[1]), .temp_vld(temp_vld_v[1]), .rst_en(rst_en_v[1]),
    .wr_en(wr_en_v[1]), .wdata(wdata_v[1]), .rd_en(rd_en_v[1]),
    .rdata(rdata_v[1]), .rdata_vld(rdata_vld_v[1]), .rdy(rdy_v[1])
  );

  // Byte-interface model: busy 20 cycles per op, read returns next queued byte
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mcnt[i]        <= 0;
        mread[i]       <= 1'b0;
        ridx[i]        <= 0;
        rdata_vld_v[i] <= 1'b0;
        rdata_v[i]     <= '0;
      end else begin
        rdata_vld_v[i] <= 1'b0;
        if (rst_en_v[i] || wr_en_v[i] || rd_en_v[i]) begin
          mcnt[i]  <= 20;
          mread[i] <= rd_en_v[i];
        end else if (mcnt[i] > 0) begin
          mcnt[i] <= mcnt[i] - 1;
          if (mcnt[i] == 1 && mread[i]) begin
            rdata_vld_v[i] <= 1'b1;
            rdata_v[i]     <= rbytes[i][ridx[i]];
            ridx[i]        <= 1 - ridx[i];
          end
        end
      end
    end
  end

  // rdy drops combinationally while a request is high
  always_comb begin
    for (int i = 0; i < 2; i++)
      rdy_v[i] = (mcnt[i] == 0) && !(rst_en_v[i] | wr_en_v[i] | rd_en_v[i]) && !stall[i];
  end

  // Request monitor: trace recording, one-hot and single-cycle pulse tracking
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mr = {rst_en_v[i], wr_en_v[i], rd_en_v[i]};
      if (!rst_n) begin
        prev_req[i] = '0;
      end else begin
        if (mr != 3'b000) begin
          if ($countones(mr) > 1 || (mr & prev_req[i]) != 3'b000) viol[i]++;
          mrec.kind = mr[2] ? 1 : (mr[1] ? 2 : 3);
          mrec.data = mr[1] ? wdata_v[i] : 8'h00;
          mrec.cyc  = cyc;
          if (i == 0) tr0.push_back(mrec);
          else        tr1.push_back(mrec);
        end
        prev_req[i] = mr;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int tr_size(input int inst);
    return (inst == 0) ? tr0.size() : tr1.size();
  endfunction

  task automatic chk_reset_outs(input string nm, input int i);
    chk(nm, 32'({rst_en_v[i], wr_en_v[i], rd_en_v[i], busy_v[i], temp_vld_v[i], wdata_v[i]}), 32'd0);
    chk({nm, "_temp_raw"}, 32'(temp_raw_v[i]), 32'd0);
  endtask

  task automatic wait_tr(input int inst, input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      if (tr_size(inst) >= n) ok = 1'b1;
      else tick;
    end
    if (!ok) chk("wait_trace_timeout", 32'(tr_size(inst)), 32'(n));
  endtask

  // One full acquisition on instance v.inst, with trace, timing and result checks
  task automatic run_acq(input vec_t v);
    int  s_cyc, v_cyc, n, d_exp;
    bit  got, stalled, dropped;
    tr_t t[$];
    rbytes[v.inst][0] = v.lsb;
    rbytes[v.inst][1] = v.msb;
    if (v.inst == 0) tr0.delete(); else tr1.delete();
    viol[v.inst] = 0;
    s_cyc = cyc;
    start_v[v.inst] = 1'b1;
    tick;
    start_v[v.inst] = 1'b0;
    chk("busy_after_start", 32'(busy_v[v.inst]), 32'd1);
    got = 1'b0; stalled = 1'b0; dropped = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      n = tr_size(v.inst);
      if (v.stall > 0 && !stalled && n == 5) begin
        stalled = 1'b1;
        stall[v.inst] = 1'b1;
        repeat (v.stall) tick;
        stall[v.inst] = 1'b0;
      end
      if (v.drop && !dropped && n == 7) begin
        dropped = 1'b1;
        start_v[v.inst] = 1'b1;
        tick;
        start_v[v.inst] = 1'b0;
      end
      if (temp_vld_v[v.inst]) got = 1'b1;
      else tick;
    end
    if (!got) begin
      chk("temp_vld_timeout", 32'(temp_vld_v[v.inst]), 32'd1);
      return;
    end
    v_cyc = cyc;
    chk("temp_raw", 32'(temp_raw_v[v.inst]), 32'(v.raw));
    chk("busy_on_vld", 32'(busy_v[v.inst]), 32'd1);
    if (v.drop) start_v[v.inst] = 1'b1;
    tick;
    start_v[v.inst] = 1'b0;
    chk("vld_single_pulse", 32'(temp_vld_v[v.inst]), 32'd0);
    chk("busy_after_vld", 32'(busy_v[v.inst]), 32'd0);
    if (v.drop) begin
      repeat (40) tick;
      chk("dropped_start_idle", 32'(busy_v[v.inst]), 32'd0);
    end
    if (v.inst == 0) t = tr0; else t = tr1;
    chk("trace_len", 32'(t.size()), 32'd8);
    if (t.size() == 8) begin
      chk("first_req_lat", 32'(t[0].cyc - s_cyc), 32'd2);
      chk("vld_lat", 32'(v_cyc - t[7].cyc), 32'(OP_LAT));
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("trace_op%0d", k), 32'({t[k].kind[7:0], t[k].data}),
            32'({eops[k].kind[7:0], eops[k].data}));
        if (k > 0) begin
          d_exp = OP_LAT;
          if (k == 3) d_exp = OP_LAT + conv_of[v.inst];
          if (k == 5 && v.stall > 0) d_exp = v.stall + 2;
          chk($sformatf("trace_gap%0d", k), 32'(t[k].cyc - t[k-1].cyc), 32'(d_exp));
        end
      end
    end
    chk("req_onehot_pulse", 32'(viol[v.inst]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    conv_of[0] = 100;
    conv_of[1] = 1;
    eops[0] = '{1, 8'h00};
    eops[1] = '{2, 8'hCC};
    eops[2] = '{2, 8'h44};
    eops[3] = '{1, 8'h00};
    eops[4] = '{2, 8'hCC};
    eops[5] = '{2, 8'hBE};
    eops[6] = '{3, 8'h00};
    eops[7] = '{3, 8'h00};
    //          lsb    msb    raw       inst stall drop
    vecs[0] = '{8'h91, 8'h01, 16'h0191, 0,   0,    1'b0};  // +25.0625 C
    vecs[1] = '{8'h5E, 8'hFF, 16'hFF5E, 0,   0,    1'b0};  // -10.125 C, back-to-back start
    vecs[2] = '{8'h6F, 8'hFE, 16'hFE6F, 0,   0,    1'b1};  // dropped starts
    vecs[3] = '{8'h50, 8'h05, 16'h0550, 1,   0,    1'b0};  // CONV_CYC = 1
    vecs[4] = '{8'hA2, 8'h00, 16'h00A2, 0,   500,  1'b0};  // rdy held low before RSP

    #1 rst_n = 1'b0;
    #1;
    chk_reset_outs("reset0", 0);
    chk_reset_outs("reset1", 1);
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (2) tick;

    foreach (vecs[i]) run_acq(vecs[i]);

    // Asynchronous reset during the conversion wait
    rbytes[0][0] = 8'h11; rbytes[0][1] = 8'h22;
    tr0.delete();
    start_v[0] = 1'b1; tick; start_v[0] = 1'b0;
    wait_tr(0, 3, ok);
    repeat (30) tick;
    chk("wait_busy_pre_rst", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_in_wait", 0);
    tick;
    rst_n = 1'b1;
    tr0.delete();
    repeat (200) tick;
    chk("idle_after_rst_wait", 32'(tr0.size()), 32'd0);

    // Asynchronous reset with the MSB read in flight
    tr0.delete();
    start_v[0] = 1'b1; tick; start_v[0] = 1'b0;
    wait_tr(0, 8, ok);
    repeat (5) tick;
    chk("rdh_busy_pre_rst", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_in_rdh", 0);
    tick;
    rst_n = 1'b1;
    tr0.delete();
    repeat (100) tick;
    chk("idle_after_rst_rdh", 32'(tr0.size()), 32'd0);
    chk("busy_after_rst_rdh", 32'(busy_v[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
